// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: bus widths, handshake levels,
// FSM encodings and operand conditioning.
package div_pkg;

    localparam int REG_W   = 32;
    localparam int DREG_W  = 64;
    localparam int STEPS   = 32;
    localparam int CNT_W   = 6;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_ANNUL            = 1'b1;
    localparam logic DIV_NO_ANNUL         = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Magnitude of an operand; 0x80000000 maps onto itself, which is what
    // makes the most-negative / -1 case wrap cleanly.
    function automatic logic [REG_W-1:0] op_mag(input logic [REG_W-1:0] v,
                                                input logic             is_signed);
        return (is_signed && v[REG_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, 32 steps, signed/unsigned, with flush and
// divide-by-zero short path. Result is {remainder, quotient}.
module div
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [REG_W-1:0]  opdata1_i,
    input  logic [REG_W-1:0]  opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [DREG_W-1:0] result_o,
    output logic              ready_o
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DREG_W:0]   dvd_q, dvd_d;
    logic [REG_W-1:0]  dvs_q, dvs_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              ready_d;
    logic [DREG_W-1:0] result_d;

    logic [REG_W:0]    diff;
    logic [REG_W-1:0]  quot, rem;

    // Compare the full 33-bit partial remainder so divisors >= 2^31 work.
    assign diff = dvd_q[DREG_W:REG_W] - {1'b0, dvs_q};
    assign quot = negq_q ? (~dvd_q[REG_W-1:0] + 1'b1) : dvd_q[REG_W-1:0];
    assign rem  = negr_q ? (~dvd_q[DREG_W:REG_W+1] + 1'b1) : dvd_q[DREG_W:REG_W+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            ready_o  <= ready_d;
            result_o <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;

        case (state_q)
            DivFree: begin
                if (start_i == DIV_START && annul_i == DIV_NO_ANNUL) begin
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                        cnt_d   = '0;
                        dvd_d   = {{REG_W{1'b0}}, op_mag(opdata1_i, signed_div_i), 1'b0};
                        dvs_d   = op_mag(opdata2_i, signed_div_i);
                        negq_d  = signed_div_i & (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                        negr_d  = signed_div_i & opdata1_i[REG_W-1];
                    end
                end
            end

            DivByZero: begin
                // Zeroed datapath makes the DONE formatting yield an all-zero result.
                dvd_d  = '0;
                dvs_d  = '0;
                negq_d = 1'b0;
                negr_d = 1'b0;
                state_d = (annul_i == DIV_ANNUL) ? DivFree : DivEnd;
            end

            DivOn: begin
                if (annul_i == DIV_ANNUL) begin
                    state_d = DivFree;
                    cnt_d   = '0;
                    dvd_d   = '0;
                    dvs_d   = '0;
                    negq_d  = 1'b0;
                    negr_d  = 1'b0;
                end else begin
                    if (diff[REG_W])
                        dvd_d = {dvd_q[DREG_W-1:0], 1'b0};
                    else
                        dvd_d = {diff[REG_W-1:0], dvd_q[REG_W-1:0], 1'b1};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(STEPS - 1))
                        state_d = DivEnd;
                end
            end

            DivEnd: begin
                if (start_i == DIV_START) begin
                    ready_d  = DIV_RESULT_READY;
                    result_d = {rem, quot};
                end else begin
                    state_d = DivFree;
                    cnt_d   = '0;
                    dvd_d   = '0;
                    dvs_d   = '0;
                    negq_d  = 1'b0;
                    negr_d  = 1'b0;
                end
            end

            default: state_d = DivFree;
        endcase
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: stimulus pushes expected results and ready cycles
// into a scoreboard; a negedge monitor checks every rising ready_o.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;
    logic ready_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, req);
    endtask

    // Monitor: each rising ready_o consumes one scoreboard entry.
    always @(negedge clk) begin
        if (ready_o === 1'b1 && ready_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_ready: got result %h want no ready", result_o);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, result_o, mon_e.res);
                check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
        ready_prev <= ready_o;
    end

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    task automatic do_op(input string nm, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res, input int lat);
        bit got;
        exp_t e;
        issue(s, a, b);
        e.res = res; e.cyc = cyc + 1 + lat; e.name = nm;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ready_o === 1'b1) begin got = 1'b1; break; end
            if (k == 2) begin
                // operands must be ignored once the divide is under way
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~s;
            end
        end
        if (!got) begin
            n_chk++;
            $display("FAIL %s_timeout: ready_o=0 after 60 cycles, want 1", nm);
            sb.delete();
            start_i = 1'b0;
            @(negedge clk);
            return;
        end
        annul_i = 1'b1;
        @(negedge clk);
        check({nm, "_hold_ready"}, 64'(ready_o), 64'd1);
        check({nm, "_hold_result"}, result_o, res);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check({nm, "_drop_ready"}, 64'(ready_o), 64'd0);
        check({nm, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_op("u_100_7",     0, 32'd100,        32'd7,          {32'h2,        32'hE},        33);
        do_op("s_m7_2",      1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        do_op("u_fff9_2",    0, 32'hFFFFFFF9,   32'h2,          {32'h1,        32'h7FFFFFFC}, 33);
        do_op("s_7_m2",      1, 32'd7,          32'hFFFFFFFE,   {32'h1,        32'hFFFFFFFD}, 33);
        do_op("s_m7_m2",     1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'h3},        33);
        do_op("u_big_dvs",   0, 32'hFFFFFFFF,   32'h80000001,   {32'h7FFFFFFE, 32'h1},        33);
        do_op("s_wrap",      1, 32'h80000000,   32'hFFFFFFFF,   {32'h0,        32'h80000000}, 33);
        do_op("u_0_5",       0, 32'd0,          32'd5,          64'd0,                        33);
        do_op("div0",        0, 32'h12345678,   32'h0,          64'd0,                        2);

        // flush mid-BUSY: annul sampled at E+10
        issue(0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); seen |= ready_o; end
        check("annul_busy_no_ready", 64'(seen), 64'd0);
        do_op("after_annul", 0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

        // flush while in DIVZERO
        issue(0, 32'h12345678, 32'h0);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= ready_o; end
        check("annul_div0_no_ready", 64'(seen), 64'd0);

        // reset mid-BUSY at E+5
        issue(0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_busy_ready", 64'(ready_o), 64'd0);
        check("rst_busy_result", result_o, 64'd0);
        start_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); seen |= ready_o; end
        check("rst_busy_no_ready", 64'(seen), 64'd0);
        rst = 1'b1;
        do_op("after_rst", 0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33);

        // reset while holding a result in DONE
        begin
            exp_t e;
            issue(0, 32'd100, 32'd7);
            e.res = {32'h2, 32'hE}; e.cyc = cyc + 34; e.name = "rst_done";
            sb.push_back(e);
            seen = 1'b0;
            for (int k = 0; k < 60 && !seen; k++) begin @(negedge clk); seen = ready_o; end
            check("rst_done_reached", 64'(seen), 64'd1);
            #2 rst = 1'b0;
            #1;
            check("rst_done_ready", 64'(ready_o), 64'd0);
            check("rst_done_result", result_o, 64'd0);
            start_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            if (sb.size() != 0) sb.delete();
        end

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
